data_memo_arbiter: RTL and testbench
====================================

# data_memo_arbiter

Two-port arbiter and sequencer that shares the single 32-entry data memory between requester 0 (core load/store path) and requester 1 (debug/DMA path). It runs round-robin arbitration with an optional lock for atomic multi-cycle sequences, and rejects out-of-range addresses. It drives the memory's address/data/enable pins and returns a registered completion per granted access. It sits between the pipeline's memory stage and the data memory module.

## Interface

Parameters:
- `LOCK_MAX`, default 8: maximum consecutive grants a locked requester may hold before forced release (range 1–15).
- `DEPTH`, default 32: memory word count (fixed power of two); valid word index is `address < DEPTH`.

Ports (bus_type = 32 bits). In the list below, "rN_" means each requester N ∈ {0,1} has its own copy of the port:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `rN_req` in 1: access request; must be held until `rN_gnt`.
- `rN_we` in 1: 1 = write, 0 = read; stable while `rN_req` is high.
- `rN_lock` in 1: request to keep ownership after this grant.
- `rN_addr` in 32: word address.
- `rN_wdata` in 32: write data.
- `rN_gnt` out 1: combinational; access is performed this cycle.
- `rN_rvalid` out 1: registered completion pulse, one cycle after the grant.
- `rN_rdata` out 32: read data; valid with `rN_rvalid`, 0 for writes and errors.
- `rN_err` out 1: valid with `rN_rvalid`; out-of-range address.
- `mem_address` out 32: to the memory address pin.
- `mem_input_data` out 32: to the memory write-data pin.
- `mem_enable_read` out 1: to the memory read-enable pin.
- `mem_enable_write` out 1: to the memory write-enable pin.
- `mem_read_data` in 32: combinational memory read output.

## Operation

- FSM states: IDLE, LOCK0, LOCK1. Reset enters IDLE.
- Round-robin pointer `prio` is 1 bit; reset value is 0, meaning requester 0 is favoured.
- IDLE: if one requester has `req` high, that requester is granted.
  - If both have `req` high, the requester indicated by `prio` is granted.
  - After any grant, `prio` flips to the other requester.
  - A granted access with `lock` high moves the FSM to LOCKn and loads `lock_cnt` with 1.
- LOCKn: only requester n can be granted; the other requester is stalled with `gnt` = 0.
  - Each grant to n increments `lock_cnt`.
  - Exit to IDLE when any of these holds:
    - `rn_req` is low;
    - `rn_lock` is low on a granted cycle (that access is still performed);
    - `lock_cnt` reaches `LOCK_MAX` (the grant at the count of `LOCK_MAX` is the last one).
  - On a forced exit, `prio` points to the other requester.
- Memory drive, per cycle:
  - `mem_address`, `mem_input_data`, `mem_enable_write` and `mem_enable_read` come from the granted requester.
  - `mem_enable_write` = `gnt & we & in_range`.
  - `mem_enable_read` = `gnt & ~we & in_range`.
  - With no grant, all four memory outputs are 0.
- `in_range` = (`addr[31:5]` == 0).
  - An out-of-range access is still granted and completes with `err` = 1 and `rdata` = 0.
  - No memory write occurs for an out-of-range access.
- Completion registers are clocked:
  - `rN_rvalid` <= `rN_gnt`.
  - `rN_rdata` <= (`gnt & ~we & in_range`) ? `mem_read_data` : 0.
  - `rN_err` <= `gnt & ~in_range`.
- At most one grant per cycle; the grants are one-hot or zero.

## Timing

- Reset (`rst_n` = 0 at a clock edge) clears:
  - state to IDLE;
  - `prio` = 0;
  - `lock_cnt` = 0;
  - all `rvalid`, `rdata`, `err` = 0.
- During reset, all `gnt` and `mem_*` outputs are 0 regardless of the requests.
- Grant latency is 0 cycles: `gnt` is asserted in the same cycle as `req` when the requester wins.
- Completion latency is 1 cycle: `rvalid` is high in cycle N+1 for a grant in cycle N.
- Write data is committed at the rising edge that ends the grant cycle.
- Read-after-write to the same address by back-to-back grants returns the new data.
- Throughput is one access per cycle. A single requester holding `req` is granted every cycle.
- Reset during LOCKn: the FSM returns to IDLE and the `rvalid` pending from the previous cycle is dropped (it is 0 after reset).
- Simultaneous events:
  - A request arriving in the cycle a lock exits is arbitrated in the next cycle using the updated `prio`.

## Test plan

- Reset: hold `rst_n` = 0 with both `req` = 1 → both `gnt` = 0, all `mem_*` = 0, `rvalid`/`rdata`/`err` = 0. Release reset → r0 is granted first.
- Single write/read: r0 writes 0xDEADBEEF to address 5 in cycle 1, then reads address 5 in cycle 2 → `r0_rvalid` in cycles 2 and 3; `r0_rdata` = 0xDEADBEEF in cycle 3.
- Contention: both requesters hold reads for 6 cycles → grants alternate 0,1,0,1,0,1 and each receives 3 `rvalid` pulses.
- Lock with `LOCK_MAX` = 8: r1 holds `lock` and `req` for 10 cycles while r0 requests → r1 is granted 8 consecutive cycles, then r0 is granted in cycle 9.
- Out of range: r0 writes 0x1234 to address 0x20, then reads address 0x20 → no memory write occurs; `r0_err` = 1 with `rdata` = 0 on both completions. Address 0 contents are unchanged.
- Reset mid-lock: reset in the 3rd cycle of LOCK0 → next cycle is IDLE, `rvalid` = 0, and a pending r1 request is granted after reset releases.

Source files
------------

// File: rtl/data_memo_arbiter_if.sv
// Requester-side handshake bundle for the data-memory arbiter: request/payload in,
// same-cycle grant and registered completion out.
interface data_memo_arbiter_if;
    localparam int unsigned BUS_W = 32;

    logic             req;
    logic             we;
    logic             lock;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [BUS_W-1:0] rdata;
    logic             err;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/data_memo_arbiter.sv
// Round-robin arbiter with bounded lock that shares one data memory between the
// core load/store path (r0) and the debug/DMA path (r1).
module data_memo_arbiter #(
    parameter int unsigned LOCK_MAX = 8,
    parameter int unsigned DEPTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_memo_arbiter_if.slave    r0,
    data_memo_arbiter_if.slave    r1,
    output logic [31:0]           mem_address,
    output logic [31:0]           mem_input_data,
    output logic                  mem_enable_read,
    output logic                  mem_enable_write,
    input  logic [31:0]           mem_read_data
);
    localparam int unsigned BUS_W = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             prio_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;
    logic             gnt0_c;
    logic             gnt1_c;
    logic             in_range0_c;
    logic             in_range1_c;

    assign in_range0_c = (r0.addr < BUS_W'(DEPTH));
    assign in_range1_c = (r1.addr < BUS_W'(DEPTH));

    // State, round-robin pointer and lock counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Grant selection and next-state; grants are forced low while reset is held
    always_comb begin
        state_nxt    = state;
        prio_nxt     = prio;
        lock_cnt_nxt = lock_cnt;
        gnt0_c       = 1'b0;
        gnt1_c       = 1'b0;

        case (state)
            IDLE: begin
                if (r0.req && (!r1.req || !prio)) begin
                    gnt0_c = 1'b1;
                end else if (r1.req) begin
                    gnt1_c = 1'b1;
                end
                if (gnt0_c) begin
                    prio_nxt = 1'b1;
                    if (r0.lock && (LOCK_MAX > 1)) begin
                        state_nxt    = LOCK0;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end else if (gnt1_c) begin
                    prio_nxt = 1'b0;
                    if (r1.lock && (LOCK_MAX > 1)) begin
                        state_nxt    = LOCK1;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            LOCK0: begin
                prio_nxt = 1'b1;
                if (!r0.req) begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                end else begin
                    gnt0_c       = 1'b1;
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    if (!r0.lock || (lock_cnt_nxt >= CNT_MAX)) begin
                        state_nxt    = IDLE;
                        lock_cnt_nxt = '0;
                    end
                end
            end
            LOCK1: begin
                prio_nxt = 1'b0;
                if (!r1.req) begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                end else begin
                    gnt1_c       = 1'b1;
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    if (!r1.lock || (lock_cnt_nxt >= CNT_MAX)) begin
                        state_nxt    = IDLE;
                        lock_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        endcase

        if (!rst_n) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end
    end

    assign r0.gnt = gnt0_c;
    assign r1.gnt = gnt1_c;

    // Memory pin mux; out-of-range accesses never enable the array
    always_comb begin
        mem_address      = '0;
        mem_input_data   = '0;
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        if (gnt0_c) begin
            mem_address      = r0.addr;
            mem_input_data   = r0.wdata;
            mem_enable_read  = !r0.we && in_range0_c;
            mem_enable_write = r0.we && in_range0_c;
        end else if (gnt1_c) begin
            mem_address      = r1.addr;
            mem_input_data   = r1.wdata;
            mem_enable_read  = !r1.we && in_range1_c;
            mem_enable_write = r1.we && in_range1_c;
        end
    end

    // Completion registers, one cycle after the grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r0.rvalid <= 1'b0;
            r0.rdata  <= '0;
            r0.err    <= 1'b0;
            r1.rvalid <= 1'b0;
            r1.rdata  <= '0;
            r1.err    <= 1'b0;
        end else begin
            r0.rvalid <= gnt0_c;
            r0.rdata  <= (gnt0_c && !r0.we && in_range0_c) ? mem_read_data : '0;
            r0.err    <= gnt0_c && !in_range0_c;
            r1.rvalid <= gnt1_c;
            r1.rdata  <= (gnt1_c && !r1.we && in_range1_c) ? mem_read_data : '0;
            r1.err    <= gnt1_c && !in_range1_c;
        end
    end
endmodule

// File: tb/tb_data_memo_arbiter.sv
// Directed bench for data_memo_arbiter: reset, write/read, contention, lock,
// out-of-range and reset-during-lock, against a behavioural 32-word memory.
module tb_data_memo_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_address;
    logic [31:0] mem_input_data;
    logic [31:0] mem_read_data;
    logic        mem_enable_read;
    logic        mem_enable_write;
    logic [31:0] mem [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memo_arbiter_if r0_if ();
    data_memo_arbiter_if r1_if ();

    data_memo_arbiter #(.LOCK_MAX(8), .DEPTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .r0               (r0_if),
        .r1               (r1_if),
        .mem_address      (mem_address),
        .mem_input_data   (mem_input_data),
        .mem_enable_read  (mem_enable_read),
        .mem_enable_write (mem_enable_write),
        .mem_read_data    (mem_read_data)
    );

    // Data memory: combinational read, write at the clock edge
    assign mem_read_data = mem[mem_address[4:0]];
    always @(posedge clk) begin
        if (mem_enable_write) mem[mem_address[4:0]] <= mem_input_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic we, input logic lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
        r0_if.req   = req;
        r0_if.we    = we;
        r0_if.lock  = lock;
        r0_if.addr  = addr;
        r0_if.wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic we, input logic lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
        r1_if.req   = req;
        r1_if.we    = we;
        r1_if.lock  = lock;
        r1_if.addr  = addr;
        r1_if.wdata = wdata;
    endtask

    initial begin
        int n0;
        int n1;
        n0 = 0;
        n1 = 0;

        // Reset held with both requesters asking to write
        rst_n = 1'b0;
        drive0(1'b1, 1'b1, 1'b0, 32'd3, 32'h1111_1111);
        drive1(1'b1, 1'b1, 1'b0, 32'd3, 32'h2222_2222);
        @(negedge clk); #1;
        check("rst_gnt0", 32'(r0_if.gnt), 32'd0);
        check("rst_gnt1", 32'(r1_if.gnt), 32'd0);
        check("rst_mem_we", 32'(mem_enable_write), 32'd0);
        check("rst_mem_re", 32'(mem_enable_read), 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_mem_wdata", mem_input_data, 32'd0);
        check("rst_rvalid0", 32'(r0_if.rvalid), 32'd0);
        check("rst_rvalid1", 32'(r1_if.rvalid), 32'd0);
        check("rst_rdata0", r0_if.rdata, 32'd0);
        check("rst_err0", 32'(r0_if.err), 32'd0);

        // Release: r0 wins on prio=0 and writes DEADBEEF to word 5
        @(negedge clk);
        rst_n = 1'b1;
        drive0(1'b1, 1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF);
        drive1(1'b1, 1'b0, 1'b0, 32'd7, 32'd0);
        #1;
        check("wr_gnt0", 32'(r0_if.gnt), 32'd1);
        check("wr_gnt1", 32'(r1_if.gnt), 32'd0);
        check("wr_mem_we", 32'(mem_enable_write), 32'd1);
        check("wr_mem_addr", mem_address, 32'd5);
        check("wr_mem_wdata", mem_input_data, 32'hDEAD_BEEF);

        // r0 reads word 5 alone
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
        drive1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("rd_gnt0", 32'(r0_if.gnt), 32'd1);
        check("rd_mem_re", 32'(mem_enable_read), 32'd1);
        check("wr_rvalid0", 32'(r0_if.rvalid), 32'd1);
        check("wr_rdata0", r0_if.rdata, 32'd0);
        check("wr_err0", 32'(r0_if.err), 32'd0);

        // Contention: prio now points at r1, grants alternate 1,0,1,0,1,0
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) begin
                drive0(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
                drive1(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
            end else begin
                drive0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                drive1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            #1;
            if (i < 6) begin
                check("cont_gnt0", 32'(r0_if.gnt), 32'(i % 2));
                check("cont_gnt1", 32'(r1_if.gnt), 32'((i + 1) % 2));
            end
            if (i == 0) begin
                check("rd_rvalid0", 32'(r0_if.rvalid), 32'd1);
                check("rd_rdata0", r0_if.rdata, 32'hDEAD_BEEF);
            end else begin
                check("cont_rv0", 32'(r0_if.rvalid), 32'((i - 1) % 2));
                check("cont_rv1", 32'(r1_if.rvalid), 32'(i % 2));
                check("cont_rdata0", r0_if.rdata, ((i - 1) % 2 == 1) ? 32'hDEAD_BEEF : 32'd0);
                check("cont_rdata1", r1_if.rdata, (i % 2 == 1) ? 32'hDEAD_BEEF : 32'd0);
                n0 += int'(r0_if.rvalid);
                n1 += int'(r1_if.rvalid);
            end
        end
        check("cont_cnt0", 32'(n0), 32'd3);
        check("cont_cnt1", 32'(n1), 32'd3);

        // Lock: prio=1, r1 holds lock for 10 cycles while r0 requests
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            drive0(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
            drive1(1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
            #1;
            check("lock_gnt1", 32'(r1_if.gnt), (j < 8 || j == 9) ? 32'd1 : 32'd0);
            check("lock_gnt0", 32'(r0_if.gnt), (j == 8) ? 32'd1 : 32'd0);
        end

        // r1 drops req while locked: r0 still stalled this cycle, granted next
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("exit_gnt0", 32'(r0_if.gnt), 32'd0);
        check("exit_gnt1", 32'(r1_if.gnt), 32'd0);
        check("exit_rv1", 32'(r1_if.rvalid), 32'd1);
        @(negedge clk); #1;
        check("post_gnt0", 32'(r0_if.gnt), 32'd1);

        // Out-of-range: seed word 0, attempt write to 0x20, read 0x20 and word 0
        @(negedge clk);
        drive0(1'b1, 1'b1, 1'b0, 32'd0, 32'hA5A5_A5A5);
        #1;
        check("seed_mem_we", 32'(mem_enable_write), 32'd1);
        @(negedge clk);
        drive0(1'b1, 1'b1, 1'b0, 32'h20, 32'h1234);
        #1;
        check("oor_wr_gnt0", 32'(r0_if.gnt), 32'd1);
        check("oor_wr_mem_we", 32'(mem_enable_write), 32'd0);
        check("oor_wr_addr", mem_address, 32'h20);
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
        #1;
        check("oor_rd_mem_re", 32'(mem_enable_read), 32'd0);
        check("oor_wr_rv0", 32'(r0_if.rvalid), 32'd1);
        check("oor_wr_err0", 32'(r0_if.err), 32'd1);
        check("oor_wr_rdata0", r0_if.rdata, 32'd0);
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("oor_rd_rv0", 32'(r0_if.rvalid), 32'd1);
        check("oor_rd_err0", 32'(r0_if.err), 32'd1);
        check("oor_rd_rdata0", r0_if.rdata, 32'd0);
        @(negedge clk);
        drive0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("w0_err0", 32'(r0_if.err), 32'd0);
        check("w0_rdata0", r0_if.rdata, 32'hA5A5_A5A5);

        // Reset in the third cycle of LOCK0 with r1 waiting
        @(negedge clk);
        drive0(1'b1, 1'b1, 1'b1, 32'd9, 32'd1);
        #1;
        check("ml_gnt0_a", 32'(r0_if.gnt), 32'd1);
        @(negedge clk);
        drive0(1'b1, 1'b1, 1'b1, 32'd9, 32'd2);
        drive1(1'b1, 1'b0, 1'b0, 32'd9, 32'd0);
        #1;
        check("ml_gnt0_b", 32'(r0_if.gnt), 32'd1);
        check("ml_stall1_b", 32'(r1_if.gnt), 32'd0);
        @(negedge clk);
        drive0(1'b1, 1'b1, 1'b1, 32'd9, 32'd3);
        #1;
        check("ml_gnt0_c", 32'(r0_if.gnt), 32'd1);
        check("ml_stall1_c", 32'(r1_if.gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        drive0(1'b1, 1'b1, 1'b1, 32'd9, 32'd4);
        #1;
        check("ml_rst_gnt0", 32'(r0_if.gnt), 32'd0);
        check("ml_rst_gnt1", 32'(r1_if.gnt), 32'd0);
        check("ml_rst_mem_we", 32'(mem_enable_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("ml_rv0", 32'(r0_if.rvalid), 32'd0);
        check("ml_gnt1", 32'(r1_if.gnt), 32'd1);
        check("ml_gnt0", 32'(r0_if.gnt), 32'd0);
        check("ml_addr", mem_address, 32'd9);
        @(negedge clk);
        drive1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("ml_rv1", 32'(r1_if.rvalid), 32'd1);
        check("ml_rdata1", r1_if.rdata, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
